// File: rtl/nios_qsys_led_pwm.sv
// Avalon-MM controlled LED dimmer/blinker sitting between the LED PIO and the pins.
// Holds a prescaled 8-bit PWM with frame-synchronous duty update and a frame-based blink gate.
module nios_qsys_led_pwm #(
  parameter int LED_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LED_W-1:0] led_in,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [LED_W-1:0] led_out
);

  logic        enable;
  logic        blink_en;
  logic [7:0]  duty;
  logic [15:0] presc;
  logic [7:0]  blink;

  logic [15:0] pcnt;
  logic [7:0]  wcnt;
  logic [7:0]  duty_act;
  logic [7:0]  fcnt;
  logic        blink_phase;

  logic        wr;
  logic        wr_ctrl;
  logic        wr_duty;
  logic        wr_presc;
  logic        wr_blink;
  logic        tick;
  logic        frame_end;
  logic        pwm_on;
  logic        gate;
  logic [7:0]  duty_next;
  logic        unused_wdata;

  assign wr        = chipselect & ~write_n;
  assign wr_ctrl   = wr & (address == 2'd0);
  assign wr_duty   = wr & (address == 2'd1);
  assign wr_presc  = wr & (address == 2'd2);
  assign wr_blink  = wr & (address == 2'd3);

  assign tick      = (pcnt == presc);
  assign frame_end = tick & (wcnt == 8'hFF);
  // a DUTY write landing on the frame_end cycle is taken by that same load
  assign duty_next = wr_duty ? writedata[7:0] : duty;
  assign pwm_on    = (wcnt < duty_act);
  assign gate      = pwm_on & (~blink_en | blink_phase);

  assign unused_wdata = ^writedata[31:16];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable   <= 1'b0;
      blink_en <= 1'b0;
      duty     <= 8'h80;
      presc    <= 16'd0;
      blink    <= 8'd0;
    end else begin
      if (wr_ctrl) begin
        enable   <= writedata[0];
        blink_en <= writedata[1];
      end
      if (wr_duty)  duty  <= writedata[7:0];
      if (wr_presc) presc <= writedata[15:0];
      if (wr_blink) blink <= writedata[7:0];
    end
  end

  // counters free-run regardless of enable; a PRESC write restarts the prescale count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt     <= 16'd0;
      wcnt     <= 8'd0;
      duty_act <= 8'h80;
    end else begin
      if (wr_presc || tick) pcnt <= 16'd0;
      else                  pcnt <= pcnt + 16'd1;
      if (tick)      wcnt     <= wcnt + 8'd1;
      if (frame_end) duty_act <= duty_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt        <= 8'd0;
      blink_phase <= 1'b1;
    end else if (blink == 8'd0) begin
      fcnt        <= 8'd0;
      blink_phase <= 1'b1;
    end else if (frame_end) begin
      if (fcnt == blink) begin
        fcnt        <= 8'd0;
        blink_phase <= ~blink_phase;
      end else begin
        fcnt <= fcnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       led_out <= '0;
    else if (enable) led_out <= led_in & {LED_W{gate}};
    else             led_out <= led_in;
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata = {30'd0, blink_en, enable};
      2'd1:    readdata = {24'd0, duty};
      2'd2:    readdata = {16'd0, presc};
      default: readdata = {24'd0, blink};
    endcase
  end

endmodule

// File: tb/tb_nios_qsys_led_pwm.sv
// Self-checking bench for nios_qsys_led_pwm: register vector table, hand-built
// corner sequences with fixed expectations, and random traffic against a tick-count model.
module tb_nios_qsys_led_pwm;

  logic        clk;
  logic        reset;
  logic [7:0]  led_in;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  led_out;

  int errors;
  int checks;

  nios_qsys_led_pwm #(.LED_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .led_in     (led_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .led_out    (led_out)
  );

  always #5 clk = ~clk;

  // reference model: PWM slot is total ticks modulo 256, frames counted per blink interval
  int       m_presc, m_pcnt, m_ticks, m_duty, m_duty_act, m_blink, m_fcnt;
  bit       m_phase, m_en, m_blen;
  logic [7:0] exp_led;

  int high_cnt;
  int zero_run;
  int max_zero_run;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        cs;
    logic        wn;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic modelReset();
    m_presc = 0; m_pcnt = 0; m_ticks = 0; m_duty = 128; m_duty_act = 128;
    m_blink = 0; m_fcnt = 0; m_phase = 1; m_en = 0; m_blen = 0;
  endtask

  function automatic logic [31:0] modelRead(input logic [1:0] a);
    case (a)
      2'd0:    return {30'd0, m_blen, m_en};
      2'd1:    return m_duty;
      2'd2:    return m_presc;
      default: return m_blink;
    endcase
  endfunction

  task automatic modelStep(input logic [7:0] li, input logic cs, input logic wn,
                           input logic [1:0] a, input logic [31:0] wd);
    bit tick, fend, on, wr;
    int slot;
    wr   = cs && !wn;
    tick = (m_pcnt == m_presc);
    slot = m_ticks % 256;
    fend = tick && (slot == 255);
    on   = (slot < m_duty_act) && (!m_blen || m_phase);
    exp_led = m_en ? (on ? li : 8'h00) : li;
    if (fend) m_duty_act = (wr && a == 2'd1) ? int'(wd[7:0]) : m_duty;
    if (m_blink == 0) begin
      m_fcnt = 0; m_phase = 1;
    end else if (fend) begin
      if (m_fcnt == m_blink) begin m_fcnt = 0; m_phase = !m_phase; end
      else m_fcnt = (m_fcnt + 1) % 256;
    end
    if (tick) m_ticks++;
    m_pcnt = (wr && a == 2'd2) ? 0 : (tick ? 0 : m_pcnt + 1);
    if (wr) begin
      case (a)
        2'd0: begin m_en = wd[0]; m_blen = wd[1]; end
        2'd1: m_duty = wd[7:0];
        2'd2: m_presc = wd[15:0];
        default: m_blink = wd[7:0];
      endcase
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock: drive inputs, advance model, compare after the edge
  task automatic applyStimulus(input logic [7:0] li, input logic cs, input logic wn,
                               input logic [1:0] a, input logic [31:0] wd);
    led_in = li; chipselect = cs; write_n = wn; address = a; writedata = wd;
    modelStep(li, cs, wn, a, wd);
    @(posedge clk); #1;
    checkOutput("led_out", {24'd0, led_out}, {24'd0, exp_led});
    checkOutput("readdata", readdata, modelRead(a));
  endtask

  task automatic regWrite(input logic [1:0] a, input logic [31:0] wd, input logic [7:0] li);
    applyStimulus(li, 1'b1, 1'b0, a, wd);
  endtask

  task automatic idleCount(input int n, input logic [7:0] li);
    high_cnt = 0; zero_run = 0; max_zero_run = 0;
    for (int i = 0; i < n; i++) begin
      applyStimulus(li, 1'b0, 1'b1, 2'd1, 32'd0);
      if (led_out != 8'h00) begin
        high_cnt++; zero_run = 0;
      end else begin
        zero_run++;
        if (zero_run > max_zero_run) max_zero_run = zero_run;
      end
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    chipselect = 1'b1; write_n = 1'b0; address = 2'd1; writedata = 32'h11;
    #1;
    checkOutput("async_reset_led", {24'd0, led_out}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    modelReset();
    #1;
    checkOutput("reset_duty_read", readdata, 32'h80);
  endtask

  initial begin
    errors = 0; checks = 0;
    clk = 0; reset = 1; led_in = 0; address = 0; chipselect = 0; write_n = 1; writedata = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;

    // reset values and pass-through with enable cleared
    applyStimulus(8'hA5, 1'b0, 1'b1, 2'd1, 32'd0);
    checkOutput("passthru_a5", {24'd0, led_out}, 32'hA5);
    checkOutput("read_duty_rst", readdata, 32'h80);
    applyStimulus(8'hA5, 1'b0, 1'b1, 2'd0, 32'd0);
    checkOutput("read_ctrl_rst", readdata, 32'h0);

    // register map vectors: write (or attempted write) then read back
    vecs[0] = '{2'd1, 32'h12345678, 1'b1, 1'b0, 32'h78};
    vecs[1] = '{2'd1, 32'h000000AA, 1'b0, 1'b0, 32'h78};
    vecs[2] = '{2'd1, 32'h000000BB, 1'b1, 1'b1, 32'h78};
    vecs[3] = '{2'd0, 32'hFFFFFFFE, 1'b1, 1'b0, 32'h2};
    vecs[4] = '{2'd0, 32'h00000005, 1'b1, 1'b0, 32'h1};
    vecs[5] = '{2'd2, 32'hABCD0003, 1'b1, 1'b0, 32'h3};
    vecs[6] = '{2'd3, 32'hFFFFFF02, 1'b1, 1'b0, 32'h2};
    vecs[7] = '{2'd3, 32'h00000000, 1'b1, 1'b0, 32'h0};
    vecs[8] = '{2'd0, 32'h00000000, 1'b1, 1'b0, 32'h0};
    vecs[9] = '{2'd2, 32'h00000000, 1'b1, 1'b0, 32'h0};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'h5A, vecs[i].cs, vecs[i].wn, vecs[i].addr, vecs[i].wdata);
      applyStimulus(8'h5A, 1'b0, 1'b1, vecs[i].addr, 32'd0);
      checkOutput($sformatf("regvec%0d", i), readdata, vecs[i].exp);
    end

    // writes during reset are ignored; steady DUTY=64 gives 64 of 256 slots
    doReset();
    regWrite(2'd0, 32'd1, 8'hFF);
    regWrite(2'd1, 32'd64, 8'hFF);
    idleCount(300, 8'hFF);
    idleCount(1024, 8'hFF);
    checkOutput("duty64_high", high_cnt, 256);

    // mid-frame DUTY change: this frame keeps 64 slots, next frame gets 192
    for (int i = 0; i < 300 && (m_ticks % 256) != 100; i++)
      applyStimulus(8'hFF, 1'b0, 1'b1, 2'd1, 32'd0);
    checkOutput("align_slot100", m_ticks % 256, 100);
    regWrite(2'd1, 32'd192, 8'hFF);
    high_cnt = (led_out != 0) ? 1 : 0;
    for (int i = 0; i < 155; i++) begin
      applyStimulus(8'hFF, 1'b0, 1'b1, 2'd1, 32'd0);
      if (led_out != 0) high_cnt++;
    end
    checkOutput("midframe_keep64", high_cnt, 0);
    idleCount(256, 8'hFF);
    checkOutput("next_frame_192", high_cnt, 192);

    // blink every two frames at full duty
    doReset();
    regWrite(2'd3, 32'd1, 8'hFF);
    regWrite(2'd1, 32'd255, 8'hFF);
    regWrite(2'd0, 32'd3, 8'hFF);
    idleCount(300, 8'hFF);
    idleCount(2048, 8'hFF);
    checkOutput("blink_high", high_cnt, 1020);
    checkOutput("blink_off_run", max_zero_run, 513);

    // prescaler of 3: each slot lasts four clocks; rewrite PRESC mid-count
    doReset();
    regWrite(2'd0, 32'd1, 8'hFF);
    regWrite(2'd1, 32'd64, 8'hFF);
    regWrite(2'd2, 32'd3, 8'hFF);
    applyStimulus(8'hFF, 1'b0, 1'b1, 2'd2, 32'd0);
    regWrite(2'd2, 32'd3, 8'hFF);
    idleCount(1100, 8'hFF);
    idleCount(4096, 8'hFF);
    checkOutput("presc3_high", high_cnt, 1024);

    // reset mid-frame at slot 100 with enable set
    doReset();
    regWrite(2'd0, 32'd1, 8'hFF);
    regWrite(2'd1, 32'd255, 8'hFF);
    idleCount(300, 8'hFF);
    for (int i = 0; i < 300 && (m_ticks % 256) != 100; i++)
      applyStimulus(8'hFF, 1'b0, 1'b1, 2'd1, 32'd0);
    checkOutput("pre_reset_led", {24'd0, led_out}, 32'hFF);
    doReset();
    applyStimulus(8'h3C, 1'b0, 1'b1, 2'd0, 32'd0);
    checkOutput("post_reset_passthru", {24'd0, led_out}, 32'h3C);
    checkOutput("post_reset_ctrl", readdata, 32'h0);
    regWrite(2'd0, 32'd1, 8'hFF);
    idleCount(256, 8'hFF);
    checkOutput("post_reset_default_duty", high_cnt, 128);

    // random register traffic and LED patterns
    doReset();
    for (int i = 0; i < 6000; i++) begin
      logic [1:0]  a;
      logic [31:0] wd;
      a  = 2'($urandom_range(0, 3));
      wd = $urandom;
      if ($urandom_range(0, 15) == 0) begin
        if (a == 2'd2) wd[15:0] = 16'($urandom_range(0, 3));
        if (a == 2'd3) wd[7:0]  = 8'($urandom_range(0, 2));
        applyStimulus(8'($urandom), 1'b1, 1'b0, a, wd);
      end else begin
        applyStimulus(8'($urandom), 1'($urandom_range(0, 1)), 1'b1, a, wd);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nios_qsys_led_pwm.md
NIOS_QSYS_LED_PWM -- requirements
Module: nios_qsys_led_pwm

Interface
REQ-001 SHALL have parameter LED_W, default 8, LED lane count (fixed at 8 in this system).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port led_in  input  8  LED pattern from the LED PIO out_port, sampled every clk.
REQ-005 SHALL have port address  input  2  Avalon-MM slave word address.
REQ-006 SHALL have port chipselect  input  1  Avalon-MM select.
REQ-007 SHALL have port write_n  input  1  Avalon-MM write strobe, active-low.
REQ-008 SHALL have port writedata  input  32  Avalon-MM write data.
REQ-009 SHALL have port readdata  output  32  Avalon-MM read data, combinational from address, zero-wait.
REQ-010 SHALL have port led_out  output  8  registered dimmed/blinked LED drive to pins.

Function
REQ-011 Register map: addr 0 CTRL {bit0 enable, bit1 blink_en}; addr 1 DUTY[7:0]; addr 2 PRESC[15:0]; addr 3 BLINK[7:0]; unused bits read 0, ignored on write.
REQ-012 Write SHALL occur when chipselect=1 and write_n=0; register updates on that clk edge.
REQ-013 readdata SHALL return the written register value (DUTY returns pending value, not active shadow).
REQ-014 Prescaler counter pcnt SHALL count 0..PRESC, then wrap to 0; tick=1 for the cycle pcnt==PRESC; PRESC=0 gives tick every cycle.
REQ-015 A write to PRESC SHALL clear pcnt to 0 on the same edge.
REQ-016 8-bit PWM counter wcnt SHALL increment on tick, wrapping 255->0; frame_end = tick and wcnt==255.
REQ-017 Active duty duty_act SHALL load from DUTY only on frame_end (glitch-free update); DUTY written on the frame_end cycle takes effect in that same load.
REQ-018 pwm_on SHALL be (wcnt < duty_act): duty_act=0 always off; duty_act=255 on 255 of 256 slots.
REQ-019 Frame counter fcnt SHALL increment on frame_end; when fcnt==BLINK on frame_end, fcnt clears and blink_phase toggles.
REQ-020 BLINK=0 SHALL hold blink_phase=1 and fcnt=0 (no blinking).
REQ-021 gate = pwm_on and (not blink_en or blink_phase).
REQ-022 led_out SHALL register: enable=0 -> led_in; enable=1 -> led_in AND {8{gate}}; latency 1 clk from led_in/state.
REQ-023 Clearing enable SHALL not reset pcnt/wcnt/fcnt; counters free-run regardless of enable.
REQ-024 Clearing blink_en SHALL not alter blink_phase; re-enabling resumes current phase.

Reset
REQ-025 On reset assertion, asynchronously: CTRL=0, DUTY=duty_act=8'h80, PRESC=0, BLINK=0, pcnt=wcnt=fcnt=0, blink_phase=1, led_out=0.
REQ-026 Reset mid-frame SHALL abort the frame; first cycle after deassertion restarts at wcnt=0.
REQ-027 Writes during reset SHALL be ignored.

Verification
REQ-028 Reset, led_in=8'hA5, no writes -> led_out=8'hA5 one clk later; readdata addr1=32'h80, addr0=0.
REQ-029 CTRL=1, DUTY=64, PRESC=0, led_in=8'hFF -> after next frame_end, led_out=8'hFF for 64 of every 256 cycles, 0 otherwise.
REQ-030 Mid-frame DUTY 64->192 -> current frame keeps 64-slot high time; next frame 192 slots.
REQ-031 CTRL=3, DUTY=255, PRESC=0, BLINK=1 -> blink_phase toggles every 2 frames (512 clk); led_out=0 throughout off phase.
REQ-032 PRESC=3 -> tick every 4 clk, frame 1024 clk; rewrite PRESC mid-count -> pcnt restarts at 0.
REQ-033 Assert reset at wcnt=100 with CTRL=1 -> led_out=0 immediately; after release wcnt=0, enable=0, led_out follows led_in.
